// File: rtl/axi_fifo_bridge_if.sv
// Message handshake bundle between the accelerator core (inside, i_*) and
// the AXI-facing shell (outside, o_*). The bridge takes the slave view; the
// environment that drives both sides takes the master view.
interface axi_fifo_bridge_if #(
  parameter int W_MSG = 64
);
  // IN channel: outside produces, inside consumes
  logic             o_in_msg_rdy;
  logic [W_MSG-1:0] o_in_msg;
  logic             o_in_msg_ack;
  logic             i_in_msg_rdy;
  logic [W_MSG-1:0] i_in_msg;
  logic             i_in_msg_ack;

  // OUT channel: inside produces, outside consumes
  logic             i_out_msg_rdy;
  logic [W_MSG-1:0] i_out_msg;
  logic             i_out_msg_ack;
  logic             o_out_msg_rdy;
  logic [W_MSG-1:0] o_out_msg;
  logic             o_out_msg_ack;

  modport slave (
    input  o_in_msg_rdy, o_in_msg, i_in_msg_ack,
    input  i_out_msg_rdy, i_out_msg, o_out_msg_ack,
    output o_in_msg_ack, i_in_msg_rdy, i_in_msg,
    output i_out_msg_ack, o_out_msg_rdy, o_out_msg
  );

  modport master (
    output o_in_msg_rdy, o_in_msg, i_in_msg_ack,
    output i_out_msg_rdy, i_out_msg, o_out_msg_ack,
    input  o_in_msg_ack, i_in_msg_rdy, i_in_msg,
    input  i_out_msg_ack, o_out_msg_rdy, o_out_msg
  );
endinterface

// File: rtl/axi_fifo_bridge.sv
// Bidirectional message bridge: two independent first-word-fall-through
// FIFOs (IN: outside -> inside, OUT: inside -> outside) with rdy/ack
// handshakes, occupancy counts and almost-full flags.
// Optional feature macro: FIFO_STATS_EN enables per-channel 16-bit
// saturating overflow (push stalled by full) and underflow (ack while
// empty) counters; when undefined the counters read 0 and stat_clr is unused.

// One FIFO channel. The producer side pushes at most every other cycle
// because its ack register masks rdy for the cycle after a capture.
module axi_fifo_bridge_chan #(
  parameter int W_MSG        = 64,
  parameter int DEPTH        = 8,
  parameter int W_LOG        = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stat_clr,
  input  logic             prod_rdy,
  input  logic [W_MSG-1:0] prod_msg,
  output logic             prod_ack,
  output logic             cons_rdy,
  output logic [W_MSG-1:0] cons_msg,
  input  logic             cons_ack,
  output logic [W_LOG:0]   count,
  output logic             afull,
  output logic [15:0]      ovf_cnt,
  output logic [15:0]      unf_cnt
);
  localparam logic [W_LOG:0]   FULL_COUNT  = (W_LOG+1)'(DEPTH);
  localparam logic [W_LOG:0]   AFULL_COUNT = (W_LOG+1)'(AFULL_THRESH);
  localparam logic [W_LOG:0]   CNT_ONE     = 1;
  localparam logic [W_LOG-1:0] PTR_ONE     = 1;

  logic [W_MSG-1:0] mem [DEPTH];
  logic [W_LOG-1:0] wr_ptr_reg;
  logic [W_LOG-1:0] rd_ptr_reg;
  logic [W_LOG:0]   count_reg;
  logic             ack_reg;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Full/empty come from pre-edge state only: a same-edge pop never frees
  // room for a push, and a same-edge push never feeds a pop.
  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);
  assign push  = prod_rdy && !ack_reg && !full;
  assign pop   = cons_ack && !empty;

  assign prod_ack = ack_reg;
  assign cons_rdy = !empty;
  assign cons_msg = empty ? '0 : mem[rd_ptr_reg];
  assign count    = count_reg;
  assign afull    = (count_reg >= AFULL_COUNT);

  // Storage write; contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= prod_msg;
    end
  end

  // Pointers, occupancy and the one-cycle producer ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ack_reg    <= 1'b0;
    end else begin
      ack_reg <= push;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef FIFO_STATS_EN
  logic ovf_event;
  logic unf_event;

  // A stall is a push that would have happened if the FIFO were not full
  assign ovf_event = prod_rdy && !ack_reg && full;
  assign unf_event = cons_ack && empty;

  // Saturating error counters; clear wins over a same-edge increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else if (stat_clr) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else begin
      if (ovf_event && (ovf_cnt != 16'hFFFF)) begin
        ovf_cnt <= ovf_cnt + 16'd1;
      end
      if (unf_event && (unf_cnt != 16'hFFFF)) begin
        unf_cnt <= unf_cnt + 16'd1;
      end
    end
  end
`else
  logic unused_stat_clr;

  assign unused_stat_clr = stat_clr;
  assign ovf_cnt         = '0;
  assign unf_cnt         = '0;
`endif
endmodule

// Top level: IN and OUT channels are the same FIFO with producer and
// consumer roles swapped between the inside and outside ports.
module axi_fifo_bridge #(
  parameter int W_MSG        = 64,
  parameter int DEPTH        = 8,
  parameter int W_LOG        = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_fifo_bridge_if.slave     bus,
  input  logic                 stat_clr,
  output logic [W_LOG:0]       in_count,
  output logic [W_LOG:0]       out_count,
  output logic                 in_afull,
  output logic                 out_afull,
  output logic [15:0]          in_ovf_cnt,
  output logic [15:0]          out_ovf_cnt,
  output logic [15:0]          in_unf_cnt,
  output logic [15:0]          out_unf_cnt
);
  axi_fifo_bridge_chan #(
    .W_MSG        (W_MSG),
    .DEPTH        (DEPTH),
    .W_LOG        (W_LOG),
    .AFULL_THRESH (AFULL_THRESH)
  ) u_in_chan (
    .clk      (clk),
    .rst      (rst),
    .stat_clr (stat_clr),
    .prod_rdy (bus.o_in_msg_rdy),
    .prod_msg (bus.o_in_msg),
    .prod_ack (bus.o_in_msg_ack),
    .cons_rdy (bus.i_in_msg_rdy),
    .cons_msg (bus.i_in_msg),
    .cons_ack (bus.i_in_msg_ack),
    .count    (in_count),
    .afull    (in_afull),
    .ovf_cnt  (in_ovf_cnt),
    .unf_cnt  (in_unf_cnt)
  );

  axi_fifo_bridge_chan #(
    .W_MSG        (W_MSG),
    .DEPTH        (DEPTH),
    .W_LOG        (W_LOG),
    .AFULL_THRESH (AFULL_THRESH)
  ) u_out_chan (
    .clk      (clk),
    .rst      (rst),
    .stat_clr (stat_clr),
    .prod_rdy (bus.i_out_msg_rdy),
    .prod_msg (bus.i_out_msg),
    .prod_ack (bus.i_out_msg_ack),
    .cons_rdy (bus.o_out_msg_rdy),
    .cons_msg (bus.o_out_msg),
    .cons_ack (bus.o_out_msg_ack),
    .count    (out_count),
    .afull    (out_afull),
    .ovf_cnt  (out_ovf_cnt),
    .unf_cnt  (out_unf_cnt)
  );
endmodule

// File: tb/tb_axi_fifo_bridge.sv
// Directed bench for axi_fifo_bridge (DEPTH=8, AFULL_THRESH=6, W_MSG=64).
// Statistics expectations follow FIFO_STATS_EN: real counts when defined,
// zero otherwise.
module tb_axi_fifo_bridge;
  localparam int W_MSG = 64;
`ifdef FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stat_clr;
  logic [3:0]  in_count;
  logic [3:0]  out_count;
  logic        in_afull;
  logic        out_afull;
  logic [15:0] in_ovf_cnt;
  logic [15:0] out_ovf_cnt;
  logic [15:0] in_unf_cnt;
  logic [15:0] out_unf_cnt;

  int vectors = 0;
  int miscompares = 0;

  axi_fifo_bridge_if #(.W_MSG(W_MSG)) bus ();

  axi_fifo_bridge #(
    .W_MSG        (W_MSG),
    .DEPTH        (8),
    .W_LOG        (3),
    .AFULL_THRESH (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .stat_clr    (stat_clr),
    .in_count    (in_count),
    .out_count   (out_count),
    .in_afull    (in_afull),
    .out_afull   (out_afull),
    .in_ovf_cnt  (in_ovf_cnt),
    .out_ovf_cnt (out_ovf_cnt),
    .in_unf_cnt  (in_unf_cnt),
    .out_unf_cnt (out_unf_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_in(input logic [63:0] data);
    bus.o_in_msg_rdy = 1'b1;
    bus.o_in_msg     = data;
    tick();
    check("in_push_ack", 64'(bus.o_in_msg_ack), 64'd1);
    bus.o_in_msg_rdy = 1'b0;
    tick();
    check("in_push_ack_drop", 64'(bus.o_in_msg_ack), 64'd0);
  endtask

  task automatic push_out(input logic [63:0] data);
    bus.i_out_msg_rdy = 1'b1;
    bus.i_out_msg     = data;
    tick();
    check("out_push_ack", 64'(bus.i_out_msg_ack), 64'd1);
    bus.i_out_msg_rdy = 1'b0;
    tick();
  endtask

  task automatic pop_out(input logic [63:0] exp);
    check("out_pop_rdy", 64'(bus.o_out_msg_rdy), 64'd1);
    check("out_pop_data", bus.o_out_msg, exp);
    bus.o_out_msg_ack = 1'b1;
    tick();
    bus.o_out_msg_ack = 1'b0;
  endtask

  initial begin
    logic [63:0] wr_n;
    logic [63:0] rd_n;

    rst               = 1'b0;
    stat_clr          = 1'b0;
    bus.o_in_msg_rdy  = 1'b0;
    bus.o_in_msg      = '0;
    bus.i_in_msg_ack  = 1'b0;
    bus.i_out_msg_rdy = 1'b0;
    bus.i_out_msg     = '0;
    bus.o_out_msg_ack = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_in_ack", 64'(bus.o_in_msg_ack), 64'd0);
    check("rst_in_rdy", 64'(bus.i_in_msg_rdy), 64'd0);
    check("rst_in_msg", bus.i_in_msg, 64'd0);
    check("rst_out_ack", 64'(bus.i_out_msg_ack), 64'd0);
    check("rst_out_rdy", 64'(bus.o_out_msg_rdy), 64'd0);
    check("rst_out_msg", bus.o_out_msg, 64'd0);
    check("rst_in_count", 64'(in_count), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_afull", 64'({in_afull, out_afull}), 64'd0);
    check("rst_stats", 64'({in_ovf_cnt, out_ovf_cnt, in_unf_cnt, out_unf_cnt}), 64'd0);
    rst = 1'b1;
    tick();

    // Single push with rdy held two cycles: exactly one ack pulse
    bus.o_in_msg_rdy = 1'b1;
    bus.o_in_msg     = 64'h1;
    tick();
    check("t1_ack_pulse", 64'(bus.o_in_msg_ack), 64'd1);
    check("t1_head_rdy", 64'(bus.i_in_msg_rdy), 64'd1);
    check("t1_head", bus.i_in_msg, 64'h1);
    check("t1_count", 64'(in_count), 64'd1);
    tick();
    check("t1_ack_low_held", 64'(bus.o_in_msg_ack), 64'd0);
    check("t1_no_dup_push", 64'(in_count), 64'd1);
    bus.o_in_msg_rdy = 1'b0;
    tick();
    check("t1_ack_low", 64'(bus.o_in_msg_ack), 64'd0);
    check("t1_count_hold", 64'(in_count), 64'd1);
    bus.i_in_msg_ack = 1'b1;
    tick();
    bus.i_in_msg_ack = 1'b0;
    check("t1_pop_rdy", 64'(bus.i_in_msg_rdy), 64'd0);
    check("t1_pop_msg", bus.i_in_msg, 64'd0);
    check("t1_pop_count", 64'(in_count), 64'd0);

    // OUT channel push/pop, IN untouched
    push_out(64'h3);
    check("t2_out_count", 64'(out_count), 64'd1);
    check("t2_in_count", 64'(in_count), 64'd0);
    pop_out(64'h3);
    check("t2_out_count0", 64'(out_count), 64'd0);
    check("t2_out_rdy0", 64'(bus.o_out_msg_rdy), 64'd0);
    check("t2_in_rdy", 64'(bus.i_in_msg_rdy), 64'd0);

    // Fill IN, almost-full at 6, then a stalled 9th push
    for (int k = 0; k < 8; k++) begin
      push_in(64'(k));
      check("t3_fill_count", 64'(in_count), 64'(k + 1));
      check("t3_afull", 64'(in_afull), ((k + 1) >= 6) ? 64'd1 : 64'd0);
    end
    bus.o_in_msg_rdy = 1'b1;
    bus.o_in_msg     = 64'h8;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_stall_ack", 64'(bus.o_in_msg_ack), 64'd0);
      check("t3_stall_count", 64'(in_count), 64'd8);
    end
    check("t3_ovf3", 64'(in_ovf_cnt), STATS ? 64'd3 : 64'd0);
    check("t3_head0", bus.i_in_msg, 64'h0);
    // Pop while full: push still blocked on this edge
    bus.i_in_msg_ack = 1'b1;
    tick();
    bus.i_in_msg_ack = 1'b0;
    check("t3_pop_count", 64'(in_count), 64'd7);
    check("t3_pop_noack", 64'(bus.o_in_msg_ack), 64'd0);
    check("t3_head1", bus.i_in_msg, 64'h1);
    tick();
    check("t3_late_ack", 64'(bus.o_in_msg_ack), 64'd1);
    check("t3_refull", 64'(in_count), 64'd8);
    bus.o_in_msg_rdy = 1'b0;
    tick();
    check("t3_ovf4", 64'(in_ovf_cnt), STATS ? 64'd4 : 64'd0);
    // Drain with ack held: one pop per cycle, order 1..8
    bus.i_in_msg_ack = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check("t3_drain", bus.i_in_msg, 64'(k));
      tick();
    end
    bus.i_in_msg_ack = 1'b0;
    check("t3_drained", 64'(in_count), 64'd0);
    check("t3_afull_clr", 64'(in_afull), 64'd0);

    // Wrap-around on OUT: count 1 -> 2 -> 3 -> 2 -> 1, 10 rounds
    wr_n = 0;
    rd_n = 0;
    push_out(64'hC0DE_0000_0000_0000 | wr_n);
    wr_n++;
    for (int r = 0; r < 10; r++) begin
      push_out(64'hC0DE_0000_0000_0000 | wr_n);
      wr_n++;
      push_out(64'hC0DE_0000_0000_0000 | wr_n);
      wr_n++;
      check("t4_count3", 64'(out_count), 64'd3);
      pop_out(64'hC0DE_0000_0000_0000 | rd_n);
      rd_n++;
      pop_out(64'hC0DE_0000_0000_0000 | rd_n);
      rd_n++;
      check("t4_count1", 64'(out_count), 64'd1);
    end
    pop_out(64'hC0DE_0000_0000_0000 | rd_n);
    check("t4_empty", 64'(out_count), 64'd0);

    // Consumer ack held on empty IN while producer pushes every 2 cycles
    bus.i_in_msg_ack = 1'b1;
    tick();
    check("t5_empty_ack", 64'(in_count), 64'd0);
    for (int m = 0; m < 4; m++) begin
      bus.o_in_msg_rdy = 1'b1;
      bus.o_in_msg     = 64'h50 + 64'(m);
      tick();
      check("t5_push_count", 64'(in_count), 64'd1);
      check("t5_head", bus.i_in_msg, 64'h50 + 64'(m));
      bus.o_in_msg_rdy = 1'b0;
      tick();
      check("t5_pop_count", 64'(in_count), 64'd0);
    end
    bus.i_in_msg_ack = 1'b0;
    check("t5_unf", 64'(in_unf_cnt), STATS ? 64'd5 : 64'd0);
    check("t5_ovf_keep", 64'(in_ovf_cnt), STATS ? 64'd4 : 64'd0);
    check("t5_out_stats", 64'({out_ovf_cnt, out_unf_cnt}), 64'd0);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("t5_clr", 64'({in_ovf_cnt, in_unf_cnt}), 64'd0);

    // Asynchronous reset mid-stream with IN holding 5 entries
    for (int k = 0; k < 5; k++) begin
      push_in(64'h60 + 64'(k));
    end
    push_out(64'h99);
    check("t6_pre_count", 64'(in_count), 64'd5);
    rst = 1'b0;
    #2;
    check("t6_in_count", 64'(in_count), 64'd0);
    check("t6_in_rdy", 64'(bus.i_in_msg_rdy), 64'd0);
    check("t6_in_msg", bus.i_in_msg, 64'd0);
    check("t6_out_count", 64'(out_count), 64'd0);
    check("t6_out_msg", bus.o_out_msg, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    push_in(64'h77);
    check("t6_repush_head", bus.i_in_msg, 64'h77);
    check("t6_repush_count", 64'(in_count), 64'd1);
    bus.i_in_msg_ack = 1'b1;
    tick();
    bus.i_in_msg_ack = 1'b0;
    check("t6_repop_count", 64'(in_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
